// File: rtl/boot_loader.sv
// UART-fed boot loader: parses a length-prefixed little-endian image, writes it to
// instruction memory and releases the core once the XOR checksum matches.
module boot_loader #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned           MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    output logic                  core_rst,
    output logic                  core_enable,
    output logic                  done,
    output logic                  error
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("boot_loader: DATA_WIDTH must be 32");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base_addr
        $error("boot_loader: BASE_ADDR must be 4-byte aligned");
    end

    typedef enum logic [2:0] {
        StLen,
        StLoad,
        StWrite,
        StCheck,
        StRun,
        StError
    } state_e;

    state_e                  state_q, state_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic [31:0]             len_q, len_d;
    logic [31:0]             word_q, word_d;
    logic [31:0]             index_q, index_d;
    logic [7:0]              csum_q, csum_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   word_offset;

    always_comb begin
        rx_ready = 1'b0;
        if (!rst) begin
            rx_ready = (state_q == StLen) || (state_q == StLoad) || (state_q == StCheck);
        end
    end

    assign accept      = rx_valid && rx_ready;
    assign word_offset = ADDR_WIDTH'(index_q) << 2;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        word_d      = word_q;
        index_d     = index_q;
        csum_d      = csum_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StLen: begin
                if (accept) begin
                    len_d      = {rx_data, len_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_d > 32'(MAX_WORDS)) begin
                            state_d = StError;
                        end else if (len_d == 32'd0) begin
                            state_d = StCheck;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
            end
            StLoad: begin
                if (accept) begin
                    word_d     = {rx_data, word_q[31:8]};
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + word_offset;
                        mem_wdata_d = DATA_WIDTH'(word_d);
                        state_d     = StWrite;
                    end
                end
            end
            StWrite: begin
                // Address/data stay frozen in their flops until the memory takes them.
                if (mem_ready) begin
                    mem_we_d = 1'b0;
                    index_d  = index_q + 32'd1;
                    state_d  = (index_d < len_q) ? StLoad : StCheck;
                end
            end
            StCheck: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? StRun : StError;
                end
            end
            StRun, StError: begin
                state_d = state_q;
            end
            default: begin
                state_d = StError;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StLen;
            byte_cnt_q  <= 2'd0;
            len_q       <= 32'd0;
            word_q      <= 32'd0;
            index_q     <= 32'd0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            word_q      <= word_d;
            index_q     <= index_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Status is gated by rst so reset values hold even before the first edge.
    assign done        = !rst && (state_q == StRun);
    assign error       = !rst && (state_q == StError);
    assign core_enable = !rst && (state_q == StRun);
    assign core_rst    = rst || (state_q != StRun);

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits directly upstream of the SoC top level. Consumes a byte stream from a UART receiver and writes the decoded program into instruction memory through a word write port.
- Holds the core in reset with execution disabled until the whole image has been loaded and its checksum verified.
- Then releases the core and drives its enable input.

Parameters:
- ADDR_WIDTH, 32, width of the memory write address.
- DATA_WIDTH, 32, memory word width. Fixed at 32; any other value is a static elaboration error.
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the image. Must be 4-byte aligned.
- MAX_WORDS, 1024, largest accepted image size in words.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  a byte is offered on rx_data.
- rx_data  in  8  offered byte.
- rx_ready  out  1  block accepts a byte this cycle; a transfer happens when rx_valid and rx_ready are both 1.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_WIDTH  write byte address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_ready  in  1  memory accepts the write this cycle.
- core_rst  out  1  active-high reset to the core/SoC.
- core_enable  out  1  execution enable to the core.
- done  out  1  image loaded and verified (sticky).
- error  out  1  load failed (sticky).

Behaviour:
- Stream format, all little-endian:
  - 4 bytes: word count N.
  - N×4 bytes: payload words.
  - 1 byte: checksum, the XOR of all payload bytes (0x00 when N=0).
- States: LEN, LOAD, WRITE, CHECK, RUN, ERROR.
- Reset values, held while rst=1:
  - state=LEN, rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_rst=1, core_enable=0, done=0, error=0.
  - Byte counter, word index and checksum accumulator all 0.
- rx_ready is 1 exactly when state is LEN, LOAD or CHECK and rst=0. It is combinational from state.
- LEN:
  - Shifts 4 accepted bytes into N; the first byte is the LSB.
  - On the 4th byte: N>MAX_WORDS goes to ERROR; N=0 goes to CHECK; otherwise LOAD.
- LOAD:
  - Assembles accepted bytes into a word, first byte to bits [7:0]. XORs each byte into the accumulator.
  - On the 4th byte of a word: the next cycle presents mem_we=1, mem_addr=BASE_ADDR+4×index, mem_wdata=the word; state goes to WRITE.
- WRITE:
  - mem_we, mem_addr and mem_wdata are held stable until a cycle with mem_ready=1.
  - In that cycle the write completes. The following cycle has mem_we=0 and index+1.
  - Next state is LOAD if index+1<N, else CHECK.
  - mem_ready is ignored while mem_we=0.
- CHECK:
  - One accepted byte. If it equals the accumulator, go to RUN; otherwise ERROR.
- RUN:
  - done=1, core_rst=0, core_enable=1, all from the cycle after the checksum byte is accepted.
  - rx bytes are not accepted.
- ERROR:
  - error=1, core_rst=1, core_enable=0, rx_ready=0. Only rst exits.
- done and error are never 1 together. core_enable=1 implies core_rst=0.
- rst asserted in any state, including mid-word or while a write is pending, returns to the reset values on the next edge. A partial word is discarded and any pending write is dropped.
- rx_valid low inside a word or the length field simply stalls; there is no timeout.
- Address arithmetic is modulo 2^ADDR_WIDTH. No bound check beyond MAX_WORDS.

Test Plan:
- Nominal load:
  - Stimulus: stream 02 00 00 00, 13 00 00 00, 6F 00 00 00, checksum 7C, with mem_ready tied 1.
  - Response: writes (0x0, 0x00000013) then (0x4, 0x0000006F). done=1, core_rst=0 and core_enable=1 the cycle after 7C is accepted.
- Memory backpressure:
  - Stimulus: as the nominal load, but mem_ready held 0 for 5 cycles on the first write.
  - Response: mem_we, addr and data stable for 6 cycles; rx_ready=0 throughout; exactly 2 writes total.
- Bad checksum:
  - Stimulus: the nominal stream with checksum 00.
  - Response: both writes occur, then error=1, done=0, core_rst stays 1, rx_ready=0.
- Length boundaries:
  - N=0 followed by checksum 00: reaches RUN with no writes.
  - N=1025 with MAX_WORDS=1024: error=1 right after the 4th length byte, no writes.
- Mid-load reset:
  - Stimulus: pulse rst after 6 payload bytes, then send the nominal stream.
  - Response: all outputs return to reset values; the reload writes start at 0x0, and done=1.
- rx_valid gaps:
  - Stimulus: random idle cycles inserted between bytes of the nominal stream.
  - Response: results identical to the nominal load.
